// File: rtl/bg_pkg.sv
// Shared types and defaults for the background band renderer.
//   region_t : per-pixel classification (sky / band / ground)
//   state_t  : lane counter state (IDLE until the first line start, then RUN)
//   SKY_IDX_DEF / GROUND_IDX_DEF : default palette indices for the flat regions
package bg_pkg;

    typedef enum logic [1:0] {
        REG_SKY    = 2'd0,
        REG_BAND   = 2'd1,
        REG_GROUND = 2'd2
    } region_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SKY_IDX_DEF    = 5;
    localparam int GROUND_IDX_DEF = 7;

endpackage

// File: rtl/bg_lane_counter.sv
// Word/lane position counter for the band renderer.
// Presents the effective (word, lane) of the current pixel combinationally and
// registers the position for the next pixel.
//   clk, rst      : clock, synchronous active-high reset
//   pix_valid     : pixel present this cycle
//   line_start    : pix_valid with x==0
//   scroll_word/scroll_lane : start position loaded at line start
//   word, lane    : effective position of the current pixel
// Macro BG_SCROLL_EN: when defined, line start loads the scroll ports;
// otherwise it loads word=0, lane=0 and the scroll ports are ignored.
module bg_lane_counter
    import bg_pkg::*;
#(
    parameter int ROW_WORDS    = 214,
    parameter int PIX_PER_WORD = 3,
    parameter int WORD_CW      = $clog2(ROW_WORDS),
    parameter int LANE_CW      = $clog2(PIX_PER_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic               line_start,
    input  logic [WORD_CW-1:0] scroll_word,
    input  logic [LANE_CW-1:0] scroll_lane,
    output logic [WORD_CW-1:0] word,
    output logic [LANE_CW-1:0] lane
);

    logic [WORD_CW-1:0] word_q, ld_word;
    logic [LANE_CW-1:0] lane_q, ld_lane;
    state_t             state;

`ifdef BG_SCROLL_EN
    // Out-of-range start positions fall back to 0.
    assign ld_word = (32'(scroll_word) < ROW_WORDS)    ? scroll_word : '0;
    assign ld_lane = (32'(scroll_lane) < PIX_PER_WORD) ? scroll_lane : '0;
`else
    logic unused_scroll;
    assign unused_scroll = ^{scroll_word, scroll_lane};
    assign ld_word = '0;
    assign ld_lane = '0;
`endif

    // The line-start pixel itself uses the loaded position; in IDLE the
    // registers sit at 0, which is the required pre-line-start rendering.
    assign word = line_start ? ld_word : word_q;
    assign lane = line_start ? ld_lane : lane_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
            state  <= ST_IDLE;
        end else if (line_start || (pix_valid && state == ST_RUN)) begin
            state <= ST_RUN;
            if (lane == LANE_CW'(PIX_PER_WORD - 1)) begin
                lane_q <= '0;
                word_q <= (word == WORD_CW'(ROW_WORDS - 1)) ? '0 : word + 1'b1;
            end else begin
                lane_q <= lane + 1'b1;
                word_q <= word;
            end
        end
    end

endmodule

// File: rtl/bg_band_renderer.sv
// Background renderer: classifies each raster pixel as sky / band / ground,
// fetches packed band pixels from background VRAM and emits one palette
// index per pixel, two edges after the pixel is sampled.
//   clk, rst      : pixel clock, synchronous active-high reset
//   pix_valid,x,y : raster position stream
//   scroll_word/scroll_lane : line-start position (used with BG_SCROLL_EN)
//   vram_addr     : registered VRAM read address (updates on band pixels only)
//   vram_rdata    : VRAM data, one cycle after vram_addr
//   index_out     : palette index, holds while index_valid=0
//   index_valid   : pix_valid delayed by two cycles
// Macro BG_SCROLL_EN enables horizontal scroll (see bg_lane_counter).
module bg_band_renderer
    import bg_pkg::*;
#(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int IDX_W        = 9,
    parameter int PIX_W        = 3,
    parameter int PIX_PER_WORD = 3,
    parameter int ROW_WORDS    = 214,
    parameter int ADDR_W       = 16,
    parameter int BAND_TOP     = 300,
    parameter int BAND_H       = 128,
    parameter int SKY_IDX      = SKY_IDX_DEF,
    parameter int GROUND_IDX   = GROUND_IDX_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pix_valid,
    input  logic [X_W-1:0]                  x,
    input  logic [Y_W-1:0]                  y,
    input  logic [$clog2(ROW_WORDS)-1:0]    scroll_word,
    input  logic [$clog2(PIX_PER_WORD)-1:0] scroll_lane,
    output logic [ADDR_W-1:0]               vram_addr,
    input  logic [PIX_W*PIX_PER_WORD-1:0]   vram_rdata,
    output logic [IDX_W-1:0]                index_out,
    output logic                            index_valid
);

    localparam int WORD_W  = PIX_W * PIX_PER_WORD;
    localparam int WORD_CW = $clog2(ROW_WORDS);
    localparam int LANE_CW = $clog2(PIX_PER_WORD);
    localparam int STAGES  = 2;

    logic               line_start;
    logic [WORD_CW-1:0] word_eff;
    logic [LANE_CW-1:0] lane_eff;
    region_t            reg_d, reg_s0, reg_s1;
    logic [LANE_CW-1:0] lane_s0, lane_s1;
    logic [STAGES:0]    vld_pipe;
    logic [PIX_W-1:0]   lane_pix;

    assign line_start  = pix_valid && (x == '0);
    assign index_valid = vld_pipe[STAGES];

    bg_lane_counter #(
        .ROW_WORDS    (ROW_WORDS),
        .PIX_PER_WORD (PIX_PER_WORD),
        .WORD_CW      (WORD_CW),
        .LANE_CW      (LANE_CW)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .line_start  (line_start),
        .scroll_word (scroll_word),
        .scroll_lane (scroll_lane),
        .word        (word_eff),
        .lane        (lane_eff)
    );

    always_comb begin
        if (32'(y) < BAND_TOP)               reg_d = REG_SKY;
        else if (32'(y) < BAND_TOP + BAND_H) reg_d = REG_BAND;
        else                                 reg_d = REG_GROUND;
    end

    // Lane 0 is the most significant PIX_W bits of the word.
    always_comb begin
        lane_pix = '0;
        for (int i = 0; i < PIX_PER_WORD; i++)
            if (32'(lane_s1) == i)
                lane_pix = vram_rdata[WORD_W-1-i*PIX_W -: PIX_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            vram_addr <= '0;
            index_out <= '0;
            reg_s0    <= REG_SKY;
            reg_s1    <= REG_SKY;
            lane_s0   <= '0;
            lane_s1   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], pix_valid};
            // stage 0: classify and issue the VRAM read
            reg_s0  <= reg_d;
            lane_s0 <= lane_eff;
            if (pix_valid && reg_d == REG_BAND)
                vram_addr <= ADDR_W'((32'(y) - 32'(BAND_TOP)) * 32'(ROW_WORDS)
                                     + 32'(word_eff));
            // stage 1: carry lane/region alongside the RAM read
            reg_s1  <= reg_s0;
            lane_s1 <= lane_s0;
            // stage 2: output register, held across gaps
            if (vld_pipe[1]) begin
                case (reg_s1)
                    REG_SKY:  index_out <= IDX_W'(SKY_IDX);
                    REG_BAND: index_out <= IDX_W'(lane_pix);
                    default:  index_out <= IDX_W'(GROUND_IDX);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bg_band_renderer.sv
module tb_bg_band_renderer;

`ifdef BG_SCROLL_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, pix_valid;
    logic [9:0]  x, y;
    logic [7:0]  scroll_word;
    logic [1:0]  scroll_lane;
    logic [15:0] vram_addr;
    logic [8:0]  vram_rdata, index_out;
    logic        index_valid;

    logic [8:0]  mem [0:65535];

    int n_vec = 0, n_miss = 0;

    bg_band_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .scroll_word (scroll_word),
        .scroll_lane (scroll_lane),
        .vram_addr   (vram_addr),
        .vram_rdata  (vram_rdata),
        .index_out   (index_out),
        .index_valid (index_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) vram_rdata <= mem[vram_addr];

    typedef struct {
        bit r; bit pv; int x; int y; int sw; int sl;
        bit ev; int ei; int ea;
    } vec_t;
    vec_t tv[$];

    task automatic add(input bit r, input bit pv, input int xx, input int yy,
                       input int s_w, input int s_l,
                       input bit ev, input int ei, input int ea);
        vec_t v;
        v = '{r, pv, xx, yy, s_w, s_l, ev, ei, ea};
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit pv, input int xx, input int yy,
                         input int s_w, input int s_l);
        rst = r; pix_valid = pv; x = 10'(xx); y = 10'(yy);
        scroll_word = 8'(s_w); scroll_lane = 2'(s_l);
    endtask

    // Reference model: pixel position counted from the line start as a flat
    // pixel number, then split into word/lane with division and modulo.
    bit m_started;
    int m_base, m_cnt, m_addr, m_hold;
    bit hv[3];
    int hi[3];

    task automatic model_reset();
        m_started = 0; m_base = 0; m_cnt = 0; m_addr = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) begin hv[i] = 0; hi[i] = 0; end
    endtask

    task automatic model_cycle(input bit r, input bit pv, input int xx, input int yy,
                               input int s_w, input int s_l);
        int pos, w, l, ldw, ldl, idx;
        if (r) begin
            model_reset();
            return;
        end
        idx = 0;
        if (pv) begin
            ldw = (SCR && s_w < 214) ? s_w : 0;
            ldl = (SCR && s_l < 3)   ? s_l : 0;
            if (xx == 0) begin
                m_started = 1; m_base = ldw * 3 + ldl; m_cnt = 0; pos = m_base;
            end else if (m_started) begin
                m_cnt++; pos = m_base + m_cnt;
            end else pos = 0;
            w = (pos / 3) % 214;
            l = pos % 3;
            if (yy < 300) idx = 5;
            else if (yy < 428) begin
                m_addr = ((yy - 300) * 214 + w) & 16'hFFFF;
                idx = (int'(mem[m_addr]) >> ((2 - l) * 3)) & 7;
            end else idx = 7;
        end
        hv[2] = hv[1]; hi[2] = hi[1];
        hv[1] = hv[0]; hi[1] = hi[0];
        hv[0] = pv;    hi[0] = idx;
        if (hv[2]) m_hold = hi[2];
    endtask

    function automatic int pick_y();
        case ($urandom_range(0, 5))
            0:       return $urandom_range(0, 599);
            1:       return $urandom_range(298, 301);
            2:       return $urandom_range(426, 429);
            default: return $urandom_range(300, 427);
        endcase
    endfunction

    initial begin
        int h, col, len, yy;
        bit r, pv;
        int s_w, s_l;

        for (int i = 0; i < 65536; i++) mem[i] = 9'($urandom);
        mem[0] = 9'o123; mem[1] = 9'o456; mem[2] = 9'o012;
        mem[214] = 9'o765; mem[215] = 9'o321;

        drive(1, 0, 0, 0, 0, 0);
        h = SCR ? 1 : 3;

        // reset
        add(1,0,0,0,0,0,     0,0,0);
        // sky row
        add(0,1,0,10,0,0,    0,0,0);
        add(0,1,1,10,0,0,    0,0,0);
        add(0,1,2,10,0,0,    1,5,0);
        add(0,1,3,10,0,0,    1,5,0);
        add(0,1,4,10,0,0,    1,5,0);
        add(0,1,5,10,0,0,    1,5,0);
        // first band row
        add(0,1,0,300,0,0,   1,5,0);
        add(0,1,1,300,0,0,   1,5,0);
        add(0,1,2,300,0,0,   1,1,0);
        add(0,1,3,300,0,0,   1,2,1);
        add(0,1,4,300,0,0,   1,3,1);
        add(0,1,5,300,0,0,   1,4,1);
        // second band row base address
        add(0,1,0,301,0,0,   1,5,214);
        add(0,0,0,301,0,0,   1,6,214);
        add(0,0,0,301,0,0,   1,7,214);
        add(0,0,0,301,0,0,   0,7,214);
        // valid gap holds counters; ground row
        add(0,1,0,300,0,0,   0,7,0);
        add(0,0,1,300,0,0,   0,7,0);
        add(0,1,1,300,0,0,   1,1,0);
        add(0,1,2,300,0,0,   0,1,0);
        add(0,1,3,300,0,0,   1,2,1);
        add(0,1,0,500,0,0,   1,3,1);
        add(0,0,0,500,0,0,   1,4,1);
        add(0,0,0,500,0,0,   1,7,1);
        add(0,0,0,500,0,0,   0,7,1);
        // scroll start word 1 lane 2
        add(0,1,0,300,1,2,   0,7,SCR?1:0);
        add(0,1,1,300,1,2,   0,7,SCR?2:0);
        add(0,1,2,300,1,2,   1,SCR?6:1,SCR?2:0);
        add(0,0,0,300,0,0,   1,SCR?0:2,SCR?2:0);
        add(0,0,0,300,0,0,   1,SCR?1:3,SCR?2:0);
        add(0,0,0,300,0,0,   0,h,SCR?2:0);
        // reset mid-band, IDLE renders word 0 lane 0 until a line start
        add(0,1,0,300,0,0,   0,h,0);
        add(0,1,1,300,0,0,   0,h,0);
        add(1,1,2,300,0,0,   0,0,0);
        add(0,1,3,300,0,0,   0,0,0);
        add(0,1,4,300,0,0,   0,0,0);
        add(0,1,0,301,0,0,   1,1,214);
        add(0,1,1,301,0,0,   1,1,214);
        add(0,1,2,301,0,0,   1,7,214);
        add(0,1,3,301,0,0,   1,6,215);
        add(0,0,0,301,0,0,   1,5,215);
        add(0,0,0,301,0,0,   1,3,215);
        add(0,0,0,301,0,0,   0,3,215);
        // out-of-range scroll loads 0
        add(0,1,0,300,250,3, 0,3,0);
        add(0,0,0,300,0,0,   0,3,0);
        add(0,0,0,300,0,0,   1,1,0);

        foreach (tv[i]) begin
            drive(tv[i].r, tv[i].pv, tv[i].x, tv[i].y, tv[i].sw, tv[i].sl);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d.valid", i), 32'(index_valid), 32'(tv[i].ev));
            chk($sformatf("tbl%0d.index", i), 32'(index_out),   32'(tv[i].ei));
            chk($sformatf("tbl%0d.addr",  i), 32'(vram_addr),   32'(tv[i].ea));
        end

        // last band row across the full word wrap
        for (int c = 0; c <= 642; c++) begin
            drive(0, 1, c, 427, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("wrap.addr x=%0d", c), 32'(vram_addr), 32'(27178 + (c / 3) % 214));
        end

        // randomized run against the model, starting with a reset
        model_reset();
        col = 3; len = 20; yy = 300;
        for (int c = 0; c < 4000; c++) begin
            r   = (c == 0) || ($urandom_range(0, 299) == 0);
            pv  = ($urandom_range(0, 3) != 0);
            s_w = $urandom_range(0, 255);
            s_l = $urandom_range(0, 3);
            drive(r, pv, col, yy, s_w, s_l);
            model_cycle(r, pv, col, yy, s_w, s_l);
            @(posedge clk); #1;
            chk("rnd.valid", 32'(index_valid), 32'(hv[2]));
            chk("rnd.index", 32'(index_out),   32'(m_hold));
            chk("rnd.addr",  32'(vram_addr),   32'(m_addr));
            if (pv) begin
                col++;
                if (col > len) begin
                    col = 0;
                    len = ($urandom_range(0, 9) == 0) ? $urandom_range(645, 700)
                                                      : $urandom_range(1, 40);
                    yy  = pick_y();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
